// File: rtl/kmean_pkg.sv
// +------------------------------------------------------------------+
// | kmean_pkg: shared constants and point type for the k-means engine |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

package kmean_pkg;

  localparam int UNIT_SIZE     = 8;
  localparam int KMAX          = 16;
  localparam int MAX_DATA_SIZE = 100;
  localparam int DW            = 32;

  localparam int X_OFS = 0;
  localparam int Y_OFS = 8;
  localparam int Z_OFS = 16;

  // Field order puts x in the low byte of the packed word.
  typedef struct packed {
    logic [UNIT_SIZE-1:0] z;
    logic [UNIT_SIZE-1:0] y;
    logic [UNIT_SIZE-1:0] x;
  } point_t;

  function automatic point_t make_point(input logic [UNIT_SIZE-1:0] x,
                                        input logic [UNIT_SIZE-1:0] y,
                                        input logic [UNIT_SIZE-1:0] z);
    point_t p;
    p.x = x;
    p.y = y;
    p.z = z;
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/divider.sv
// +------------------------------------------------------------------+
// | divider: combinational restoring array, unsigned q/r, den=0 rule  |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module divider #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] num,
  input  logic [DW-1:0] den,
  output logic [DW-1:0] q,
  output logic [DW-1:0] r
);

  logic [DW-1:0] w_quo;
  logic [DW-1:0] w_rem;
  logic [DW:0]   w_shift;
  logic [DW:0]   w_diff;

  // One unrolled stage per quotient bit, MSB first. The partial remainder
  // stays below den, so the shifted value always fits in DW+1 bits.
  always_comb begin
    w_quo   = '0;
    w_rem   = '0;
    w_shift = '0;
    w_diff  = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      w_shift = {w_rem, num[i]};
      w_diff  = w_shift - {1'b0, den};
      if (w_shift >= {1'b0, den}) begin
        w_quo[i] = 1'b1;
        w_rem    = w_diff[DW-1:0];
      end else begin
        w_rem    = w_shift[DW-1:0];
      end
    end
  end

  assign q = (den == '0) ? '1  : w_quo;
  assign r = (den == '0) ? num : w_rem;

endmodule

`default_nettype wire

// File: rtl/mem_block.sv
// +------------------------------------------------------------------+
// | mem_block: single-port point memory, registered read, range guard |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module mem_block #(
  parameter  int WEL  = 24,
  parameter  int SIZE = 100,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we,
  input  logic [WEL-1:0] din,
  input  logic [AW-1:0]  addr,
  output logic [WEL-1:0] dout
);

  logic [WEL-1:0] mem_q [SIZE];
  logic [WEL-1:0] dout_q;
  logic [WEL-1:0] dout_d;
  logic           w_in_range;

  assign w_in_range = (32'(addr) < SIZE);

  always_comb begin
    dout_d = '0;
    if (w_in_range) begin
      dout_d = mem_q[addr];
    end
  end

  // Storage is deliberately left out of the reset branch: only the read
  // register clears, and writes simply cannot happen while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
      if (we && w_in_range) begin
        mem_q[addr] <= din;
      end
    end
  end

  assign dout = dout_q;

endmodule

`default_nettype wire

// File: rtl/divider_mem.sv
// +------------------------------------------------------------------+
// | divider_mem: wrapper placing point memory and divider side by side|
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module divider_mem
  import kmean_pkg::*;
#(
  parameter  int WEL  = 3 * UNIT_SIZE,
  parameter  int SIZE = MAX_DATA_SIZE,
  parameter  int DW   = 32,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we,
  input  logic [WEL-1:0] din,
  input  logic [AW-1:0]  addr,
  output logic [WEL-1:0] dout,
  input  logic [DW-1:0]  num,
  input  logic [DW-1:0]  den,
  output logic [DW-1:0]  q,
  output logic [DW-1:0]  r
);

  mem_block #(
    .WEL  (WEL),
    .SIZE (SIZE)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .din   (din),
    .addr  (addr),
    .dout  (dout)
  );

  divider #(
    .DW (DW)
  ) u_div (
    .num (num),
    .den (den),
    .q   (q),
    .r   (r)
  );

endmodule

`default_nettype wire

// File: tb/tb_divider_mem.sv
// Testbench for divider_mem: scoreboarded memory reads plus directed and
// random divider checks.
`default_nettype none

module tb_divider_mem;

  localparam int WEL  = 24;
  localparam int SIZE = 100;
  localparam int DW   = 32;
  localparam int AW   = $clog2(SIZE);

  typedef struct {
    logic [WEL-1:0] exp;
    int             a;
  } rd_t;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic           we    = 1'b0;
  logic [WEL-1:0] din   = '0;
  logic [AW-1:0]  addr  = '0;
  logic [WEL-1:0] dout;
  logic [DW-1:0]  num   = '0;
  logic [DW-1:0]  den   = '0;
  logic [DW-1:0]  q;
  logic [DW-1:0]  r;

  int n_checks = 0;
  int n_err    = 0;

  logic [WEL-1:0] model [SIZE];
  bit             known [SIZE];
  rd_t            sb [$];

  divider_mem #(
    .WEL  (WEL),
    .SIZE (SIZE),
    .DW   (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .din   (din),
    .addr  (addr),
    .dout  (dout),
    .num   (num),
    .den   (den),
    .q     (q),
    .r     (r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_check();
    rd_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("dout@%0d", e.a), {8'h0, dout}, {8'h0, e.exp});
    end
  endtask

  // One clock step: check the read issued last step, then drive this one.
  task automatic cycle(input logic w, input int a, input logic [WEL-1:0] d);
    rd_t e;
    @(negedge clk);
    pop_check();
    we   = w;
    addr = AW'(a);
    din  = d;
    if (a >= SIZE) begin
      e.exp = '0; e.a = a; sb.push_back(e);
    end else if (known[a]) begin
      e.exp = model[a]; e.a = a; sb.push_back(e);
    end
    if (w && a < SIZE) begin
      model[a] = d;
      known[a] = 1'b1;
    end
  endtask

  task automatic div_check(input logic [DW-1:0] n, input logic [DW-1:0] d,
                           input logic [DW-1:0] eq, input logic [DW-1:0] er);
    num = n;
    den = d;
    #1;
    check($sformatf("q %0d/%0d", n, d), q, eq);
    check($sformatf("r %0d/%0d", n, d), r, er);
  endtask

  initial begin
    logic [DW-1:0] rn, rd;

    // Async reset: dout must clear without a clock edge.
    #1 reset = 1'b0;
    #1 check("reset_dout", {8'h0, dout}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < SIZE; i++) begin
      cycle(1'b1, i, {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A});
    end

    cycle(1'b1, 0,  24'h0A141E);
    cycle(1'b1, 99, 24'hFFFFFF);
    cycle(1'b1, 5,  24'h111111);
    cycle(1'b0, 0,  '0);
    cycle(1'b0, 99, '0);

    // Out-of-range write must not alias into the array.
    cycle(1'b1, 100, 24'h123456);
    cycle(1'b0, 100, '0);
    for (int i = 0; i < SIZE; i++) begin
      cycle(1'b0, i, '0);
    end

    // Read-during-write: old data this cycle, new data next.
    cycle(1'b1, 5, 24'h222222);
    cycle(1'b0, 5, '0);
    cycle(1'b0, 0, '0);
    @(negedge clk);
    pop_check();
    we = 1'b0;

    #2 reset = 1'b0;
    #1 check("rst_mid_dout", {8'h0, dout}, 32'h0);
    we   = 1'b1;
    addr = '0;
    din  = 24'hDEAD00;
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_dout", {8'h0, dout}, 32'h0);
    we    = 1'b0;
    reset = 1'b1;
    cycle(1'b0, 0, '0);
    cycle(1'b0, 5, '0);
    @(negedge clk);
    pop_check();
    check("sb_empty", 32'(sb.size()), 32'd0);

    div_check(32'd1000,      32'd7,   32'd142,      32'd6);
    div_check(32'd25500,     32'd100, 32'd255,      32'd0);
    div_check(32'd3,         32'd9,   32'd0,        32'd3);
    div_check(32'hFFFFFFFF,  32'd1,   32'hFFFFFFFF, 32'd0);
    div_check(32'd77,        32'd0,   32'hFFFFFFFF, 32'd77);
    div_check(32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,   32'd0);
    div_check(32'hFFFFFFFE,  32'hFFFFFFFF, 32'd0,   32'hFFFFFFFE);
    div_check(32'h80000000,  32'h80000001, 32'd0,   32'h80000000);
    div_check(32'd0,         32'd0,   32'hFFFFFFFF, 32'd0);
    for (int i = 0; i < 24; i++) begin
      rn = $urandom;
      rd = $urandom >> $urandom_range(0, 31);
      if (rd == '0) rd = 32'd1;
      div_check(rn, rd, rn / rd, rn % rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
